// File: rtl/dds_wave_addr_gen.sv
// dds_wave_addr_gen
// DDS address generator/sequencer for the 8-bit x 256 waveform ROMs.
// A phase accumulator issues registered ROM addresses, the ROM data is
// captured one clock later and presented as a registered sample with a
// qualifier. Runs are continuous or a fixed number of accumulator periods.
// Optional feature: define DDS_AMP_SCALE_EN to add the amp input and scale
// each sample by amp/256 inside the output register stage.
module dds_wave_addr_gen #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [PHASE_WIDTH-1:0] fword,
    input  logic [ADDR_WIDTH-1:0]  pword,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   cfg_load,
    input  logic                   start,
    input  logic                   stop,
`ifdef DDS_AMP_SCALE_EN
    input  logic [DATA_WIDTH-1:0]  amp,
`endif
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_q,
    output logic [DATA_WIDTH-1:0]  sample,
    output logic                   sample_valid,
    output logic                   cycle_wrap,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Phase accumulator and the sum including its carry (carry = wrap).
    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH:0]   acc_sum;

    // Active configuration used by the accumulator.
    logic [PHASE_WIDTH-1:0] fword_s;
    logic [ADDR_WIDTH-1:0]  pword_s;
    logic [BURST_WIDTH-1:0] blen_s;

    // Retune requested while running; waits for the next wrap so the
    // frequency/phase change lands on a period boundary.
    logic [PHASE_WIDTH-1:0] fword_p;
    logic [ADDR_WIDTH-1:0]  pword_p;
    logic                   pend_valid;

    // Completed periods of the current run.
    logic [BURST_WIDTH-1:0] period_cnt;
    logic [BURST_WIDTH-1:0] cnt_inc;
    logic                   final_period;

    // Second cycle of the drain window.
    logic                   drain_cnt;

    // Control strobes decoded from the FSM.
    logic                   start_run;
    logic                   issue;
    logic                   wrap_now;
    logic                   drain_last;

    // Qualifier pipeline: address issued -> ROM data ready -> sample out.
    logic                   addr_vld;
    logic                   q_vld;
    logic [DATA_WIDTH-1:0]  sample_d;

    assign acc_sum      = {1'b0, acc} + {1'b0, fword_s};
    assign cnt_inc      = period_cnt + BURST_WIDTH'(1);
    assign final_period = (blen_s != '0) && (cnt_inc == blen_s);
    assign wrap_now     = issue && acc_sum[PHASE_WIDTH];
    assign busy         = (state != ST_IDLE);

`ifdef DDS_AMP_SCALE_EN
    logic [2*DATA_WIDTH-1:0] scaled;
    assign scaled   = {{DATA_WIDTH{1'b0}}, rom_q} * {{DATA_WIDTH{1'b0}}, amp};
    assign sample_d = DATA_WIDTH'(scaled >> DATA_WIDTH);
`else
    assign sample_d = rom_q;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; stop wins over start in IDLE and over issuing in RUN.
    always_comb begin
        next_state = state;
        start_run  = 1'b0;
        issue      = 1'b0;
        drain_last = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    next_state = ST_RUN;
                    start_run  = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    next_state = ST_DRAIN;
                end else begin
                    issue = en;
                    if (en && acc_sum[PHASE_WIDTH] && final_period) begin
                        next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt) begin
                    next_state = ST_IDLE;
                    drain_last = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Drain timer: two cycles in DRAIN before returning to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= 1'b0;
        end else begin
            drain_cnt <= (state == ST_DRAIN);
        end
    end

    // Configuration shadows: direct load in IDLE, wrap-aligned retune otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fword_s    <= '0;
            pword_s    <= '0;
            blen_s     <= '0;
            fword_p    <= '0;
            pword_p    <= '0;
            pend_valid <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (cfg_load) begin
                fword_s    <= fword;
                pword_s    <= pword;
                blen_s     <= burst_len;
                pend_valid <= 1'b0;
            end
        end else begin
            if (wrap_now && pend_valid) begin
                fword_s <= fword_p;
                pword_s <= pword_p;
            end
            if (cfg_load) begin
                fword_p    <= fword;
                pword_p    <= pword;
                pend_valid <= 1'b1;
            end else if (wrap_now) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Phase accumulator: cleared on start, advances only when an address issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (start_run) begin
            acc <= '0;
        end else if (issue) begin
            acc <= acc_sum[PHASE_WIDTH-1:0];
        end
    end

    // ROM address from the accumulator MSBs plus the phase offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
        end else if (issue) begin
            rom_addr <= acc[PHASE_WIDTH-1 -: ADDR_WIDTH] + pword_s;
        end
    end

    // Period counter and the one-clock wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            cycle_wrap <= 1'b0;
        end else begin
            cycle_wrap <= wrap_now;
            if (start_run) begin
                period_cnt <= '0;
            end else if (wrap_now) begin
                period_cnt <= cnt_inc;
            end
        end
    end

    // Valid pipeline matching the ROM read latency plus the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_vld     <= 1'b0;
            q_vld        <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            addr_vld     <= issue;
            q_vld        <= addr_vld;
            sample_valid <= q_vld;
        end
    end

    // Output sample register; holds its last value between valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample <= '0;
        end else if (q_vld) begin
            sample <= sample_d;
        end
    end

    // End-of-run pulse on the transition back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= drain_last;
        end
    end

endmodule

// File: tb/tb_dds_wave_addr_gen.sv
// tb_dds_wave_addr_gen
// Scoreboard bench: a phase-arithmetic reference model predicts samples,
// wrap/done pulses and per-cycle busy/rom_addr; a negedge monitor compares.
// Define DDS_AMP_SCALE_EN to exercise the amplitude-scaled build.
module tb_dds_wave_addr_gen;

    localparam int PW = 32;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int BW = 16;
    localparam longint MOD = 64'h1_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          cfg_load = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [PW-1:0] fword = '0;
    logic [AW-1:0] pword = '0;
    logic [BW-1:0] burst_len = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q = '0;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          cycle_wrap;
    logic          busy;
    logic          done;
`ifdef DDS_AMP_SCALE_EN
    logic [DW-1:0] amp = 8'hFF;
`endif

    logic [DW-1:0] rom [256];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    int samp_cnt = 0;
    int wrap_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t samp_q[$];
    exp_t wrap_q[$];
    exp_t done_q[$];
    exp_t stat_q[$];
    exp_t mon_e;

    // Reference model state (0 idle, 1 run, 2 drain).
    int     m_state = 0;
    int     m_dleft = 0;
    longint m_phase = 0;
    longint m_f = 0;
    int     m_p = 0;
    int     m_blen = 0;
    int     m_count = 0;
    bit     m_pend = 1'b0;
    longint m_pf = 0;
    int     m_pp = 0;
    int     m_addr = 0;

    dds_wave_addr_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .fword        (fword),
        .pword        (pword),
        .burst_len    (burst_len),
        .cfg_load     (cfg_load),
        .start        (start),
        .stop         (stop),
`ifdef DDS_AMP_SCALE_EN
        .amp          (amp),
`endif
        .rom_addr     (rom_addr),
        .rom_q        (rom_q),
        .sample       (sample),
        .sample_valid (sample_valid),
        .cycle_wrap   (cycle_wrap),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read ROM with one clock of latency.
    always @(posedge clk) rom_q <= rom[rom_addr];

    function automatic exp_t mk(input int c, input int v);
        exp_t r;
        r.cyc = c;
        r.val = v;
        return r;
    endfunction

    function automatic int exp_sample(input int v);
`ifdef DDS_AMP_SCALE_EN
        return (v * int'(amp)) >> DW;
`else
        return v;
`endif
    endfunction

    function automatic logic [PW-1:0] rand_fword();
        logic [PW-1:0] f;
        f = ($urandom_range(1, 48) << 24) | ($urandom & 32'h00FF_FFFF);
        return f;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Predict what the upcoming clock edge does with the inputs now applied.
    task automatic model_edge();
        int k;
        int a;
        bit wrapped;
        k = cyc + 1;
        wrapped = 1'b0;
        case (m_state)
            0: begin
                if (cfg_load) begin
                    m_f = longint'(fword);
                    m_p = int'(pword);
                    m_blen = int'(burst_len);
                    m_pend = 1'b0;
                end
                if (start && !stop) begin
                    m_state = 1;
                    m_phase = 0;
                    m_count = 0;
                end
            end
            1: begin
                if (stop) begin
                    m_state = 2;
                    m_dleft = 2;
                end else if (en) begin
                    a = int'(((m_phase >> (PW - AW)) + longint'(m_p)) % 256);
                    m_addr = a;
                    samp_q.push_back(mk(k + 2, exp_sample(int'(rom[a]))));
                    m_phase = m_phase + m_f;
                    if (m_phase >= MOD) begin
                        m_phase = m_phase - MOD;
                        wrapped = 1'b1;
                        m_count++;
                        wrap_q.push_back(mk(k, 0));
                        if (m_pend) begin
                            m_f = m_pf;
                            m_p = m_pp;
                        end
                        if (m_blen != 0 && m_count == m_blen) begin
                            m_state = 2;
                            m_dleft = 2;
                        end
                    end
                end
                if (cfg_load) begin
                    m_pf = longint'(fword);
                    m_pp = int'(pword);
                    m_pend = 1'b1;
                end else if (wrapped) begin
                    m_pend = 1'b0;
                end
            end
            default: begin
                if (cfg_load) begin
                    m_pf = longint'(fword);
                    m_pp = int'(pword);
                    m_pend = 1'b1;
                end
                m_dleft--;
                if (m_dleft == 0) begin
                    m_state = 0;
                    done_q.push_back(mk(k, 0));
                end
            end
        endcase
        stat_q.push_back(mk(k, (m_state != 0 ? 256 : 0) + m_addr));
    endtask

    task automatic apply_stimulus(input logic e, input logic c, input logic s, input logic p);
        en = e;
        cfg_load = c;
        start = s;
        stop = p;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n;
        n = 0;
        while ((busy || m_state != 0) && n < max_cycles) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check_output("idle_timeout", busy, 0);
        idle_cycles(3);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic reset_dut();
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_rom_addr", rom_addr, 0);
        check_output("rst_sample", sample, 0);
        check_output("rst_sample_valid", sample_valid, 0);
        check_output("rst_cycle_wrap", cycle_wrap, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        samp_q.delete();
        wrap_q.delete();
        done_q.delete();
        stat_q.delete();
        m_state = 0;
        m_dleft = 0;
        m_phase = 0;
        m_f = 0;
        m_p = 0;
        m_blen = 0;
        m_count = 0;
        m_pend = 1'b0;
        m_pf = 0;
        m_pp = 0;
        m_addr = 0;
        en = 1'b0;
        cfg_load = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("busy_after_reset", busy, 0);
        mon_en = 1'b1;
    endtask

    // Monitor: compare every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            while (stat_q.size() > 0 && stat_q[0].cyc < cyc) void'(stat_q.pop_front());
            if (stat_q.size() > 0 && stat_q[0].cyc == cyc) begin
                mon_e = stat_q.pop_front();
                check_output("busy", busy, mon_e.val / 256);
                check_output("rom_addr", rom_addr, mon_e.val % 256);
            end

            if (sample_valid) samp_cnt++;
            if (cycle_wrap) wrap_cnt++;
            if (done) done_cnt++;

            if (samp_q.size() > 0 && samp_q[0].cyc <= cyc) begin
                mon_e = samp_q.pop_front();
                check_output("sample_valid", sample_valid, 1);
                if (sample_valid) check_output("sample", sample, mon_e.val);
            end else if (sample_valid) begin
                check_output("sample_valid_extra", sample_valid, 0);
            end

            if (wrap_q.size() > 0 && wrap_q[0].cyc <= cyc) begin
                void'(wrap_q.pop_front());
                check_output("cycle_wrap", cycle_wrap, 1);
            end else if (cycle_wrap) begin
                check_output("cycle_wrap_extra", cycle_wrap, 0);
            end

            if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
                void'(done_q.pop_front());
                check_output("done", done, 1);
            end else if (done) begin
                check_output("done_extra", done, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);

        @(posedge clk);
        #1;
        reset_dut();

        // Continuous ramp, step 1 address per clock.
        fword = 32'h0100_0000;
        pword = 8'h00;
        burst_len = '0;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
        run_until_idle(10);

        // Three-period burst at 16 addresses per period.
        fword = 32'h1000_0000;
        burst_len = 16'd3;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        samp_cnt = 0;
        wrap_cnt = 0;
        done_cnt = 0;
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
        run_until_idle(200);
        check_output("burst_samples", samp_cnt, 48);
        check_output("burst_wraps", wrap_cnt, 3);
        check_output("burst_done", done_cnt, 1);
        check_output("burst_busy_after", busy, 0);

        // Mid-run retune from step 1 to step 2, aligned to the next wrap.
        fword = 32'h0100_0000;
        burst_len = '0;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        fword = 32'h0200_0000;
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
        run_until_idle(10);

        // Pause for five clocks mid-run.
        fword = 32'h0100_0000;
        pword = 8'h10;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
        run_until_idle(10);

        // Phase offset 0x80 crossing 0xFF->0x00, then abort.
        pword = 8'h80;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
        run_until_idle(10);

        // start and stop together in IDLE must not launch a run.
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
        idle_cycles(3);

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            fword = rand_fword();
            pword = 8'($urandom);
            burst_len = 16'($urandom_range(0, 3));
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
            apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
            for (int i = 0; i < 600 && m_state != 0; i++) begin
                logic e;
                logic c;
                logic s;
                logic p;
                e = ($urandom_range(0, 3) != 0);
                c = ($urandom_range(0, 40) == 0);
                s = ($urandom_range(0, 20) == 0);
                p = ($urandom_range(0, 300) == 0);
                if (c) begin
                    fword = rand_fword();
                    pword = 8'($urandom);
                    burst_len = 16'($urandom_range(0, 3));
                end
                apply_stimulus(e, c, s, p);
            end
            if (m_state == 1) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
            run_until_idle(10);
        end

        // Asynchronous reset in the middle of a run.
        fword = 32'h0100_0000;
        pword = 8'h00;
        burst_len = '0;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        reset_dut();
        idle_cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
